// File: rtl/mvu_pe_acc_seq_pkg.sv
// mvu_pkg: shared FSM state, delay-line flag type and sign-extension helper for the MVU PE accumulator
package mvu_pkg;
  typedef enum logic [1:0] {ACC, DRAIN, HOLD} acc_state_t;
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } flag_t;
  function automatic logic [31:0] sext_acc(input logic [31:0] v, input int w);
    return 32'($signed(v << (32 - w)) >>> (32 - w));
  endfunction
endpackage

// File: rtl/mvu_pe_acc_seq_if.sv
// mvu_pe_acc_seq_if: beat-gating and result-stream signals between a PE accumulator and its environment
interface mvu_pe_acc_seq_if #(
  parameter int TDSTI = 4,
  parameter int TACC  = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [TDSTI-1:0] tree_sum;
  logic             out_valid;
  logic             out_ready;
  logic [TACC-1:0]  out_data;
  logic             out_last;
  modport master (output in_valid, tree_sum, out_ready, input in_ready, out_valid, out_data, out_last);
  modport slave  (input in_valid, tree_sum, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/mvu_pe_acc_seq_flag_delay.sv
// mvu_flag_delay: LAT-stage shift register tracking beat flags through the adder-tree pipeline
module mvu_flag_delay
  import mvu_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic  clock,
  input  logic  resetn,
  input  flag_t din_i,
  output flag_t dout_o
);
  flag_t [LAT-1:0] sr_q;
  always_ff @(posedge clock) begin
    if (!resetn) sr_q <= '0;
    else begin
      sr_q[0] <= din_i;
      for (int i = 1; i < LAT; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign dout_o = sr_q[LAT-1];
endmodule

// File: rtl/mvu_pe_acc_seq.sv
// mvu_pe_acc_seq: gates SIMD beats into the adder tree, accumulates SF folds, streams NF neuron results
module mvu_pe_acc_seq
  import mvu_pkg::*;
#(
  parameter int SIMD     = 2,
  parameter int TDstI    = 4,
  parameter int TAcc     = 8,
  parameter int SF       = 4,
  parameter int NF       = 2,
  parameter int TREE_LAT = 1
) (
  input logic             clock,
  input logic             resetn,
  mvu_pe_acc_seq_if.slave bus
);
  localparam int SFW = SF > 1 ? $clog2(SF) : 1;
  localparam int NFW = NF > 1 ? $clog2(NF) : 1;
  if (SIMD < 1 || TAcc < TDstI || TAcc > 32 || SF < 1 || NF < 1 || TREE_LAT < 1) begin : g_bad_params
    $error("mvu_pe_acc_seq: illegal parameter set");
  end
  acc_state_t      state_q;
  logic [SFW-1:0]  sf_q;
  logic [NFW-1:0]  nf_q;
  logic [TAcc-1:0] acc_q, acc_d, sum, out_data_q;
  logic            out_valid_q, out_last_q, accept;
  flag_t           push_flag, pop_flag;
  assign bus.in_ready  = resetn && state_q == ACC;
  assign bus.out_valid = resetn && out_valid_q;
  assign bus.out_data  = resetn ? out_data_q : '0;
  assign bus.out_last  = resetn && out_last_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign push_flag     = '{vld: accept, first: sf_q == '0, last: sf_q == SFW'(SF - 1)};
  assign sum           = TAcc'(sext_acc(32'(bus.tree_sum), TDstI));
  assign acc_d         = pop_flag.vld ? (pop_flag.first ? sum : acc_q + sum) : acc_q;
  mvu_flag_delay #(.LAT(TREE_LAT)) u_flag_delay (
    .clock (clock),
    .resetn(resetn),
    .din_i (push_flag),
    .dout_o(pop_flag)
  );
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ACC;
      sf_q        <= '0;
      nf_q        <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      case (state_q)
        ACC: if (accept) begin
          sf_q <= push_flag.last ? '0 : sf_q + 1'b1;
          if (push_flag.last) state_q <= DRAIN;
        end
        DRAIN: if (pop_flag.vld && pop_flag.last) begin
          out_data_q  <= acc_d;
          out_valid_q <= 1'b1;
          out_last_q  <= nf_q == NFW'(NF - 1);
          state_q     <= HOLD;
        end
        HOLD: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          nf_q        <= nf_q == NFW'(NF - 1) ? '0 : nf_q + 1'b1;
          state_q     <= ACC;
        end
        default: state_q <= ACC;
      endcase
    end
  end
  // HOLD never overlaps the tree pipeline, so a flag arriving there means a lost partial sum
  a_no_vld_in_hold: assert property (@(posedge clock) disable iff (!resetn)
    !(state_q == HOLD && pop_flag.vld));
  a_out_stable: assert property (@(posedge clock) disable iff (!resetn)
    out_valid_q && !bus.out_ready |=> $stable(out_data_q) && $stable(out_last_q));
endmodule

// File: tb/tb_mvu_pe_acc_seq.sv
// tb_mvu_pe_acc_seq: directed checks of fold accumulation, back-pressure, reset and parameter corners
module tb_mvu_pe_acc_seq;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [3:0] beat0 = '0, beat1 = '0, beat2 = '0;
  logic [3:0] t0, t1;
  logic [3:0] t2 [3];
  always #5 clock = ~clock;
  mvu_pe_acc_seq_if #(.TDSTI(4), .TACC(8)) if0 (), if1 (), if2 ();
  mvu_pe_acc_seq #(.SIMD(2), .TDstI(4), .TAcc(8), .SF(4), .NF(2), .TREE_LAT(1)) u0 (
    .clock(clock), .resetn(resetn), .bus(if0.slave));
  mvu_pe_acc_seq #(.SIMD(2), .TDstI(4), .TAcc(8), .SF(16), .NF(2), .TREE_LAT(1)) u1 (
    .clock(clock), .resetn(resetn), .bus(if1.slave));
  mvu_pe_acc_seq #(.SIMD(2), .TDstI(4), .TAcc(8), .SF(1), .NF(3), .TREE_LAT(3)) u2 (
    .clock(clock), .resetn(resetn), .bus(if2.slave));
  // adder-tree stand-ins: junk value 5 enters on non-accepted cycles and must be ignored
  always @(posedge clock) begin
    t0    <= (if0.in_valid && if0.in_ready) ? beat0 : 4'h5;
    t1    <= (if1.in_valid && if1.in_ready) ? beat1 : 4'h5;
    t2[0] <= (if2.in_valid && if2.in_ready) ? beat2 : 4'h5;
    t2[1] <= t2[0];
    t2[2] <= t2[1];
  end
  assign if0.tree_sum = t0;
  assign if1.tree_sum = t1;
  assign if2.tree_sum = t2[2];
  task automatic tick();
    @(negedge clock);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive0(input logic [15:0] b, input bit gap);
    for (int i = 0; i < 4; i++) begin
      beat0 = b[15-4*i -: 4];
      if0.in_valid = 1'b1;
      tick();
      if (gap && i < 3) begin
        if0.in_valid = 1'b0;
        tick();
        chk("gap_in_ready", 32'(if0.in_ready), 1);
      end
    end
    if0.in_valid = 1'b0;
  endtask
  task automatic fold0(input logic [15:0] b, input bit gap, input logic [7:0] ed, input logic el);
    if0.out_ready = 1'b1;
    drive0(b, gap);
    chk("drain_out_valid", 32'(if0.out_valid), 0);
    chk("drain_in_ready", 32'(if0.in_ready), 0);
    tick();
    chk("res_out_valid", 32'(if0.out_valid), 1);
    chk("res_out_data", 32'(if0.out_data), 32'(ed));
    chk("res_out_last", 32'(if0.out_last), 32'(el));
    tick();
    chk("ack_out_valid", 32'(if0.out_valid), 0);
    chk("ack_in_ready", 32'(if0.in_ready), 1);
  endtask
  task automatic fold2(input logic [3:0] b, input logic [7:0] ed, input logic el);
    beat2 = b;
    if2.in_valid = 1'b1;
    tick();
    if2.in_valid = 1'b0;
    chk("l3_in_ready", 32'(if2.in_ready), 0);
    tick();
    tick();
    chk("l3_early_valid", 32'(if2.out_valid), 0);
    tick();
    chk("l3_out_valid", 32'(if2.out_valid), 1);
    chk("l3_out_data", 32'(if2.out_data), 32'(ed));
    chk("l3_out_last", 32'(if2.out_last), 32'(el));
    tick();
    chk("l3_ack_valid", 32'(if2.out_valid), 0);
    chk("l3_ack_ready", 32'(if2.in_ready), 1);
  endtask
  initial begin
    if0.in_valid = 1'b0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(if0.in_ready), 0);
    chk("rst_out_valid", 32'(if0.out_valid), 0);
    chk("rst_out_data", 32'(if0.out_data), 0);
    chk("rst_out_last", 32'(if0.out_last), 0);
    chk("rst_l3_in_ready", 32'(if2.in_ready), 0);
    resetn = 1'b1;
    tick();
    chk("idle_in_ready", 32'(if0.in_ready), 1);
    fold0(16'h3333, 1'b0, 8'h0C, 1'b0);
    fold0(16'h3333, 1'b0, 8'h0C, 1'b1);
    fold0(16'h1111, 1'b0, 8'h04, 1'b0);
    fold0(16'h78FF, 1'b0, 8'hFD, 1'b1);
    fold0(16'h3333, 1'b1, 8'h0C, 1'b0);
    if0.out_ready = 1'b0;
    drive0(16'h2222, 1'b0);
    tick();
    chk("hold_out_valid", 32'(if0.out_valid), 1);
    chk("hold_out_data", 32'(if0.out_data), 8'h08);
    chk("hold_out_last", 32'(if0.out_last), 1);
    beat0 = 4'h7;
    if0.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_out_valid", 32'(if0.out_valid), 1);
      chk("stall_in_ready", 32'(if0.in_ready), 0);
      chk("stall_out_data", 32'(if0.out_data), 8'h08);
    end
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    tick();
    chk("release_out_valid", 32'(if0.out_valid), 0);
    chk("release_in_ready", 32'(if0.in_ready), 1);
    tick();
    chk("release_single", 32'(if0.out_valid), 0);
    beat0 = 4'h7;
    if0.in_valid = 1'b1;
    tick();
    tick();
    if0.in_valid = 1'b0;
    resetn = 1'b0;
    tick();
    chk("midfold_rst_valid", 32'(if0.out_valid), 0);
    chk("midfold_rst_ready", 32'(if0.in_ready), 0);
    chk("midfold_rst_data", 32'(if0.out_data), 0);
    resetn = 1'b1;
    tick();
    chk("midfold_post_valid", 32'(if0.out_valid), 0);
    fold0(16'h1234, 1'b0, 8'h0A, 1'b0);
    if0.out_ready = 1'b0;
    drive0(16'h4444, 1'b0);
    tick();
    chk("hrst_out_valid", 32'(if0.out_valid), 1);
    chk("hrst_out_data", 32'(if0.out_data), 8'h10);
    resetn = 1'b0;
    tick();
    chk("hrst_rst_valid", 32'(if0.out_valid), 0);
    chk("hrst_rst_last", 32'(if0.out_last), 0);
    resetn = 1'b1;
    tick();
    tick();
    chk("hrst_post_valid", 32'(if0.out_valid), 0);
    fold0(16'h1111, 1'b0, 8'h04, 1'b0);
    beat1 = 4'h7;
    if1.in_valid = 1'b1;
    repeat (16) tick();
    if1.in_valid = 1'b0;
    chk("sf16_drain_valid", 32'(if1.out_valid), 0);
    tick();
    chk("sf16_out_valid", 32'(if1.out_valid), 1);
    chk("sf16_out_data", 32'(if1.out_data), 8'h70);
    chk("sf16_out_last", 32'(if1.out_last), 0);
    fold2(4'h9, 8'hF9, 1'b0);
    fold2(4'h2, 8'h02, 1'b0);
    fold2(4'h8, 8'hF8, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
